sub16_serial: RTL and testbench
===============================

Name: sub16_serial

Overview:
- Multi-cycle unsigned subtractor; the inverse-direction companion to the team's byte-serial 16-bit adder.
- Computes in1 - in2 on WIDTH-bit operands through one SLICE-bit subtract datapath, least-significant slice first.
- Borrow is chained between slices in a register.
- Sits beside the adder in the arithmetic block and uses a start/busy/done handshake, so a controller can issue operations back-to-back.

Parameters:
- WIDTH, 16, operand and result width; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle; must be ≥2.
- NSLICE, derived as WIDTH/SLICE (localparam, not overridable); 2 at defaults.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- in1  input  WIDTH  minuend; captured on the accepting edge
- in2  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result and borrow_out are valid
- result  output  WIDTH  difference in1 - in2, modulo 2^WIDTH
- borrow_out  output  1  1 when in1 < in2 (unsigned)

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Ports are named clock and reset_n.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, borrow_out=0.
  - Internal operand registers, accumulator, borrow register and slice counter are cleared.
- Reset mid-operation aborts the operation. No done is produced, and result/borrow_out read 0.
- States: IDLE, SLICE, FINISH.
- IDLE:
  - If start=1 at edge E0: latch in1 and in2, clear the borrow register and slice counter, go to SLICE, busy<=1, done<=0.
  - Otherwise: done<=0; result and borrow_out hold.
- SLICE, edges E1..E(NSLICE):
  - Each edge computes {b, d} = {0, a_s} - {0, b_s} - borrow, where a_s/b_s are the current slices.
  - d is shifted into the accumulator at the MSB end; the operand registers shift right by SLICE; borrow<=b; counter increments.
  - After the NSLICE-th slice, go to FINISH.
- FINISH, edge E(NSLICE+1):
  - result<=accumulator, borrow_out<=borrow, done<=1, busy<=0, state<=IDLE.
- Latency and throughput:
  - done is high for exactly one cycle, after edge E(NSLICE+1) (E3 at defaults).
  - start sampled high at the edge that clears done is accepted, giving back-to-back throughput of one operation per NSLICE+2 cycles (4 at defaults).
- start while busy=1 is ignored; in1/in2 changes during an operation have no effect.
- result/borrow_out change only at FINISH (or reset) and hold indefinitely otherwise.
- Arithmetic: pure unsigned, modulo 2^WIDTH; borrow_out is the final borrow of the MSB slice.

Optional Feature:
- Macro: SUB16_SERIAL_SAT_EN.
- Defined: at FINISH, if the final borrow=1 then result<=0 (clamp at zero); borrow_out is still 1. Latency is unchanged.
- Undefined: result is the wrapped modulo-2^WIDTH difference.

Test Plan:
- Basic: in1=0x1234, in2=0x0034, start pulse -> busy high for 3 cycles; done pulse after E3; result=0x1200, borrow_out=0.
- Inter-slice borrow: 0x0100 - 0x0001 -> result=0x00FF, borrow_out=0.
- Underflow: 0x0000 - 0x0001 -> result=0xFFFF, borrow_out=1. With SUB16_SERIAL_SAT_EN: result=0x0000, borrow_out=1.
- Start while busy:
  - Start 0x5000-0x1000, then assert start with 0xFFFF-0x0001 one cycle later.
  - Required: only one done; result=0x4000; the second request is not queued.
- Reset mid-op:
  - Start 0x8888-0x1111, drop reset_n for one cycle after E1 -> busy=0, done=0, result=0, no done afterwards.
  - A new 0x8888-0x1111 then yields 0x7777 after 3 cycles.
- Back-to-back: start held high with 0xFFFF-0xFFFF, then 0x0002-0x0003 -> done every 4 cycles; results 0x0000/borrow 0, then 0xFFFF/borrow 1.

Source files
------------

// File: rtl/sub16_serial.sv
// rtl/sub16_serial.sv - slice-serial unsigned subtractor (in1 - in2) with start/busy/done handshake
// Optional macro SUB16_SERIAL_SAT_EN clamps an underflowing result to zero.
module sub16_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             borrow_out
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SLICE  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
   logic             borrow_q, borrow_d, bout_q, bout_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SLICE:0]   diff;
   logic [WIDTH-1:0] acc_shift;

   // Zero-extended subtract: bit SLICE of the difference is the outgoing borrow.
   assign diff = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, borrow_q};

   generate
      if (NSLICE > 1) begin : g_multi
         assign acc_shift = {diff[SLICE-1:0], acc_q[WIDTH-1:SLICE]};
      end else begin : g_single
         assign acc_shift = diff[SLICE-1:0];
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = done_q;
      result_d = result_q;
      bout_d   = bout_q;
      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (start) begin
               a_d      = in1;
               b_d      = in2;
               borrow_d = 1'b0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = S_SLICE;
            end
         end
         S_SLICE: begin
            acc_d    = acc_shift;
            a_d      = a_q >> SLICE;
            b_d      = b_q >> SLICE;
            borrow_d = diff[SLICE];
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) state_d = S_FINISH;
         end
         S_FINISH: begin
`ifdef SUB16_SERIAL_SAT_EN
            result_d = borrow_q ? '0 : acc_q;
`else
            result_d = acc_q;
`endif
            bout_d   = borrow_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         bout_q   <= bout_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign result     = result_q;
   assign borrow_out = bout_q;

endmodule

// File: tb/tb_sub16_serial.sv
// tb/tb_sub16_serial.sv - scoreboard bench for sub16_serial
module tb_sub16_serial;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        borrow_out;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   logic done_prev = 1'b0;
   logic [16:0] sb[$];

   sub16_serial #(.WIDTH(16), .SLICE(8)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .in1        (in1),
      .in2        (in2),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .borrow_out (borrow_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] d;
      d = {1'b0, a} - {1'b0, b};
`ifdef SUB16_SERIAL_SAT_EN
      if (d[16]) d[15:0] = 16'h0000;
`endif
      return d;
   endfunction

   always @(negedge clock) begin
      if (done) begin
         done_cnt++;
         if (done_prev) check("done_width", 32'd2, 32'd1);
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [16:0] e;
            e = sb.pop_front();
            check("result", {16'h0, result}, {16'h0, e[15:0]});
            check("borrow", {31'h0, borrow_out}, {31'h0, e[16]});
         end
      end
      done_prev = done;
   end

   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit push);
      in1   = a;
      in2   = b;
      start = 1'b1;
      if (push) sb.push_back(model(a, b));
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat);
      int n;
      n = 0;
      while (!done && n < 12) begin
         @(posedge clock); #1;
         n++;
      end
      check(tag, n, lat);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [16:0] m;
      reset_n = 1'b0;
      start   = 1'b0;
      in1     = 16'h0;
      in2     = 16'h0;
      idle(2);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_result", {16'h0, result}, 32'd0);
      check("rst_borrow", {31'h0, borrow_out}, 32'd0);
      reset_n = 1'b1;
      idle(2);

      // Basic: busy for three cycles, then a single done.
      start_op(16'h1234, 16'h0034, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("basic_busy", {31'h0, busy}, 32'd1);
         check("basic_nodone", {31'h0, done}, 32'd0);
         @(posedge clock); #1;
      end
      check("basic_busy_end", {31'h0, busy}, 32'd0);
      check("basic_done", {31'h0, done}, 32'd1);
      idle(1);
      check("basic_done_clr", {31'h0, done}, 32'd0);
      idle(3);
      m = model(16'h1234, 16'h0034);
      check("basic_hold", {16'h0, result}, {16'h0, m[15:0]});

      start_op(16'h0100, 16'h0001, 1'b1);
      wait_done("lat_interslice", 3);
      idle(2);
      start_op(16'h0000, 16'h0001, 1'b1);
      wait_done("lat_underflow", 3);
      idle(2);

      // Second request while busy must be dropped.
      base = done_cnt;
      start_op(16'h5000, 16'h1000, 1'b1);
      in1   = 16'hFFFF;
      in2   = 16'h0001;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done("lat_busy_start", 2);
      idle(8);
      check("busy_start_count", done_cnt - base, 32'd1);

      // Reset mid-operation aborts without a done.
      base = done_cnt;
      start_op(16'h8888, 16'h1111, 1'b0);
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      check("abort_busy", {31'h0, busy}, 32'd0);
      check("abort_done", {31'h0, done}, 32'd0);
      check("abort_result", {16'h0, result}, 32'd0);
      check("abort_borrow", {31'h0, borrow_out}, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      idle(6);
      check("abort_no_done", done_cnt - base, 32'd0);
      start_op(16'h8888, 16'h1111, 1'b1);
      wait_done("lat_after_abort", 3);
      idle(2);

      // Back-to-back with start held high; operand change mid-op must not leak in.
      in1   = 16'hFFFF;
      in2   = 16'hFFFF;
      start = 1'b1;
      sb.push_back(model(16'hFFFF, 16'hFFFF));
      @(posedge clock); #1;
      in1 = 16'h0002;
      in2 = 16'h0003;
      sb.push_back(model(16'h0002, 16'h0003));
      wait_done("lat_b2b_1", 3);
      @(posedge clock); #1;
      check("b2b_busy", {31'h0, busy}, 32'd1);
      start = 1'b0;
      wait_done("lat_b2b_2", 3);
      idle(2);

      for (int k = 0; k < 6; k++) begin
         start_op(16'($urandom), 16'($urandom), 1'b1);
         wait_done("lat_rand", 3);
         idle(1);
      end

      idle(5);
      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
